// File: rtl/ascon_ctrl_fsm_if.sv
// Handshake and control bundle between the Ascon encryption sequencer and
// the datapath/host it drives.
interface ascon_ctrl_fsm_if;
  logic       start_i;
  logic       data_valid_i;
  logic       ready_o;
  logic [3:0] round_o;
  logic       enable_o;
  logic       selectionp_o;
  logic       xor_data_begin_o;
  logic       xor_key_begin_o;
  logic       xor_key_end_o;
  logic       xor_lsb_end_o;
  logic       en_cipher_o;
  logic       en_tag_o;
  logic       cipher_valid_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output start_i,
    output data_valid_i,
    input  ready_o,
    input  round_o,
    input  enable_o,
    input  selectionp_o,
    input  xor_data_begin_o,
    input  xor_key_begin_o,
    input  xor_key_end_o,
    input  xor_lsb_end_o,
    input  en_cipher_o,
    input  en_tag_o,
    input  cipher_valid_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start_i,
    input  data_valid_i,
    output ready_o,
    output round_o,
    output enable_o,
    output selectionp_o,
    output xor_data_begin_o,
    output xor_key_begin_o,
    output xor_key_end_o,
    output xor_lsb_end_o,
    output en_cipher_o,
    output en_tag_o,
    output cipher_valid_o,
    output busy_o,
    output done_o
  );
endinterface

// File: rtl/ascon_ctrl_fsm.sv
// Sequencer for one Ascon-128 encryption: p12 init, one AD block, NB_BLOCKS
// plaintext blocks (the last absorbed in finalization), p12 finalization.
module ascon_ctrl_fsm #(
  parameter int unsigned NB_BLOCKS = 4
) (
  input logic             clock_i,
  input logic             reset_i,
  ascon_ctrl_fsm_if.slave bus
);

  localparam int unsigned BW       = $clog2(NB_BLOCKS + 1);
  localparam logic [3:0]  RND_P12  = 4'd0;
  localparam logic [3:0]  RND_P6   = 4'd6;
  localparam logic [3:0]  RND_LAST = 4'd11;
  localparam logic [BW-1:0] BLK_LAST = BW'(NB_BLOCKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_AD,
    AD,
    WAIT_PT,
    PT,
    FINAL,
    END
  } state_t;

  typedef struct packed {
    logic ready;
    logic enable;
    logic selectionp;
    logic xor_data_begin;
    logic xor_key_begin;
    logic xor_key_end;
    logic xor_lsb_end;
    logic en_cipher;
    logic en_tag;
    logic busy;
    logic done;
  } ctrl_t;

  state_t        state, state_n;
  logic [3:0]    rnd, rnd_n;
  logic [BW-1:0] blk, blk_n;
  ctrl_t         ctrl, ctrl_n;
  logic          cipher_valid;
  logic          rnd_last;
  logic [3:0]    rnd_inc;

  assign rnd_last = (rnd == RND_LAST);
  assign rnd_inc  = rnd + 4'd1;

  // Output decode for a given state/round; applied to the next state so the
  // registered strobes line up with the state they belong to.
  function automatic ctrl_t decode(input state_t s, input logic [3:0] r);
    ctrl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      INIT: begin
        c.enable      = 1'b1;
        c.selectionp  = (r != RND_P12);
        c.xor_key_end = (r == RND_LAST);
      end
      WAIT_AD, WAIT_PT: begin
        c.ready = 1'b1;
      end
      AD: begin
        c.enable         = 1'b1;
        c.selectionp     = 1'b1;
        c.xor_data_begin = (r == RND_P6);
        c.xor_lsb_end    = (r == RND_LAST);
      end
      PT: begin
        c.enable         = 1'b1;
        c.selectionp     = 1'b1;
        c.xor_data_begin = (r == RND_P6);
        c.en_cipher      = (r == RND_P6);
      end
      FINAL: begin
        c.enable         = 1'b1;
        c.selectionp     = 1'b1;
        c.xor_data_begin = (r == RND_P12);
        c.xor_key_begin  = (r == RND_P12);
        c.en_cipher      = (r == RND_P12);
        c.xor_key_end    = (r == RND_LAST);
        c.en_tag         = (r == RND_LAST);
      end
      END: begin
        c.done = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_n = state;
    rnd_n   = rnd;
    blk_n   = blk;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          state_n = INIT;
          rnd_n   = RND_P12;
          blk_n   = '0;
        end
      end
      INIT: begin
        if (rnd_last) state_n = WAIT_AD;
        else          rnd_n   = rnd_inc;
      end
      WAIT_AD: begin
        if (bus.data_valid_i) begin
          state_n = AD;
          rnd_n   = RND_P6;
        end
      end
      AD: begin
        if (rnd_last) state_n = WAIT_PT;
        else          rnd_n   = rnd_inc;
      end
      WAIT_PT: begin
        if (bus.data_valid_i) begin
          blk_n = blk + BW'(1);
          if (blk == BLK_LAST) begin
            state_n = FINAL;
            rnd_n   = RND_P12;
          end else begin
            state_n = PT;
            rnd_n   = RND_P6;
          end
        end
      end
      PT: begin
        if (rnd_last) state_n = WAIT_PT;
        else          rnd_n   = rnd_inc;
      end
      FINAL: begin
        if (rnd_last) state_n = END;
        else          rnd_n   = rnd_inc;
      end
      END: begin
        state_n = IDLE;
        rnd_n   = '0;
        blk_n   = '0;
      end
      default: begin
        state_n = IDLE;
        rnd_n   = '0;
        blk_n   = '0;
      end
    endcase
    ctrl_n = decode(state_n, rnd_n);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      rnd          <= '0;
      blk          <= '0;
      ctrl         <= '0;
      cipher_valid <= 1'b0;
    end else begin
      state        <= state_n;
      rnd          <= rnd_n;
      blk          <= blk_n;
      ctrl         <= ctrl_n;
      cipher_valid <= ctrl.en_cipher;
    end
  end

  assign bus.ready_o          = ctrl.ready;
  assign bus.round_o          = rnd;
  assign bus.enable_o         = ctrl.enable;
  assign bus.selectionp_o     = ctrl.selectionp;
  assign bus.xor_data_begin_o = ctrl.xor_data_begin;
  assign bus.xor_key_begin_o  = ctrl.xor_key_begin;
  assign bus.xor_key_end_o    = ctrl.xor_key_end;
  assign bus.xor_lsb_end_o    = ctrl.xor_lsb_end;
  assign bus.en_cipher_o      = ctrl.en_cipher;
  assign bus.en_tag_o         = ctrl.en_tag;
  assign bus.cipher_valid_o   = cipher_valid;
  assign bus.busy_o           = ctrl.busy;
  assign bus.done_o           = ctrl.done;

endmodule
